rect_draw_datapath: RTL



---
 rtl/rect_draw_if.sv | 29 ++
 rtl/rect_draw_datapath.sv | 98 +++++++++
 2 files changed

// File: rtl/rect_draw_if.sv
// Pixel-sweep bus between the rectangle control FSM (master) and the draw datapath (slave).
// The master drives the load strobes, start pulse and sources; the slave returns the pixel write.
interface rect_draw_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                ld_x;
    logic                ld_y;
    logic                start_count;
    logic [X_W-1:0]      coord_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output ld_x, ld_y, start_count, coord_in, colour_in,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  ld_x, ld_y, start_count, coord_in, colour_in,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/rect_draw_datapath.sv
// Sweeps a fixed BOX_W x BOX_H box from a snapshotted origin, one pixel write per cycle.
// Optional macro RECT_CLIP_EN: suppress plot for pixels outside SCREEN_W x SCREEN_H.
module rect_draw_datapath #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    rect_draw_if.slave  bus
);
    localparam int CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

    if (BOX_W < 1 || BOX_H < 1 || SCREEN_W < 1 || SCREEN_H < 1 || Y_W > X_W) begin : g_param_check
        $error("rect_draw_datapath: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t              state;
    logic [X_W-1:0]      x_reg, x0;
    logic [Y_W-1:0]      y_reg, y0;
    logic [COLOUR_W-1:0] col_reg, c0;
    logic [CX_W-1:0]     cx;
    logic [CY_W-1:0]     cy;
    logic                in_view;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cx      <= '0;
            cy      <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            col_reg <= '0;
            x0      <= '0;
            y0      <= '0;
            c0      <= '0;
        end else begin
            // Load registers are independent of the sweep; x0/y0/c0 hold the active box.
            if (bus.ld_x) x_reg <= bus.coord_in;
            if (bus.ld_y) begin
                y_reg   <= bus.coord_in[Y_W-1:0];
                col_reg <= bus.colour_in;
            end
            case (state)
                IDLE: begin
                    if (bus.start_count) begin
                        state <= DRAW;
                        x0    <= x_reg;
                        y0    <= y_reg;
                        c0    <= col_reg;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                DRAW: begin
                    if (cx == CX_LAST) begin
                        cx <= '0;
                        if (cy == CY_LAST) state <= DONE;
                        else               cy    <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RECT_CLIP_EN
    // Unwrapped sums so that a box running off the right/bottom edge is clipped, not wrapped.
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    assign sum_x     = {1'b0, x0} + (X_W+1)'(cx);
    assign sum_y     = {1'b0, y0} + (Y_W+1)'(cy);
    assign in_view   = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    assign bus.x_out = sum_x[X_W-1:0];
    assign bus.y_out = sum_y[Y_W-1:0];
`else
    assign in_view   = 1'b1;
    assign bus.x_out = x0 + X_W'(cx);
    assign bus.y_out = y0 + Y_W'(cy);
`endif

    assign bus.colour_out = c0;
    assign bus.busy       = (state == DRAW);
    assign bus.plot       = (state == DRAW) && in_view;
    assign bus.done       = (state == DONE);
endmodule
